// File: rtl/rs232_tx_arbiter_pkg.sv
// Shared definitions for the RS232 transmit arbiter: FSM encoding, timing defaults,
// byte-count width shared with the encoder, and the hold-time helper.
package rs232_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    localparam int DEF_BYTE_CYCLES  = 12;
    localparam int DEF_GUARD_CYCLES = 4;
    localparam int NUM_BYTES_W      = 4;
    localparam int IDX_W            = 3;
    localparam int HOLD_W           = 10;

    // 15 bytes * 63 cycles + 63 guard still fits in HOLD_W bits, so no truncation.
    function automatic logic [HOLD_W-1:0] hold_load(input logic [NUM_BYTES_W-1:0] num_bytes,
                                                    input int byte_cycles,
                                                    input int guard_cycles);
        return HOLD_W'(num_bytes) * HOLD_W'(byte_cycles) + HOLD_W'(guard_cycles);
    endfunction

endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after rr_ptr_i, wrapping modulo NUM_REQ.
module rs232_rr_pick
    import rs232_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               found_o
);

    // Scan offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req_i[j] && (j == ((int'(rr_ptr_i) + k) % NUM_REQ))) begin
                    winner_o = IDX_W'(j);
                    found_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one RS232 encoder port; holds off for the computed frame time.
// Optional macro RS232_TX_ARB_PRIO0_EN gives requester 0 absolute priority.
module rs232_tx_arbiter
    import rs232_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BYTES    = 6,
    parameter int BYTE_CYCLES  = DEF_BYTE_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0]     req_bytes,
    input  logic [NUM_REQ*NUM_BYTES_W-1:0]     req_num_bytes,
    output logic [NUM_REQ-1:0]                 req_ack,
    output logic [NUM_REQ-1:0]                 req_err,
    output logic [MAX_BYTES*8-1:0]             tx_bytes,
    output logic [NUM_BYTES_W-1:0]             tx_num_bytes,
    output logic                               tx_valid,
    output logic                               busy,
    output logic [IDX_W-1:0]                   grant_idx
);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [MAX_BYTES*8-1:0]  tx_bytes_q, tx_bytes_d;
    logic [NUM_BYTES_W-1:0]  tx_num_bytes_q, tx_num_bytes_d;
    logic [IDX_W-1:0]        grant_q, grant_d;

    logic [IDX_W-1:0]        rr_winner, winner, rr_next;
    logic                    found;
    logic [NUM_BYTES_W-1:0]  win_num;
    logic [MAX_BYTES*8-1:0]  win_bytes;
    logic                    win_bad;
    logic [NUM_REQ-1:0]      win_sel, gnt_sel;

    rs232_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (rr_winner),
        .found_o  (found)
    );

`ifdef RS232_TX_ARB_PRIO0_EN
    assign winner = req_valid[0] ? '0 : rr_winner;
`else
    assign winner = rr_winner;
`endif

    assign win_num   = req_num_bytes[int'(winner)*NUM_BYTES_W +: NUM_BYTES_W];
    assign win_bytes = req_bytes[int'(winner)*MAX_BYTES*8 +: MAX_BYTES*8];
    assign win_bad   = (win_num == '0) || (int'(win_num) > MAX_BYTES);
    assign rr_next   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 3'd1;

    always_comb begin
        win_sel = '0;
        gnt_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_sel[i] = (int'(winner) == i);
            gnt_sel[i] = (int'(grant_q) == i);
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        hold_d         = hold_q;
        tx_bytes_d     = tx_bytes_q;
        tx_num_bytes_d = tx_num_bytes_q;
        grant_d        = grant_q;
        req_ack        = '0;
        req_err        = '0;
        tx_valid       = 1'b0;
        busy           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Reject ack is combinational, so it is masked while reset is held.
                if (found && reset_n) begin
                    rr_ptr_d = rr_next;
                    if (win_bad) begin
                        req_ack = win_sel;
                        req_err = win_sel;
                    end else begin
                        tx_bytes_d     = win_bytes;
                        tx_num_bytes_d = win_num;
                        grant_d        = winner;
                        state_d        = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                req_ack  = gnt_sel;
                hold_d   = hold_load(tx_num_bytes_q, BYTE_CYCLES, GUARD_CYCLES);
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                busy   = 1'b1;
                hold_d = hold_q - 10'd1;
                if (hold_q <= 10'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            hold_q         <= '0;
            tx_bytes_q     <= '0;
            tx_num_bytes_q <= '0;
            grant_q        <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            hold_q         <= hold_d;
            tx_bytes_q     <= tx_bytes_d;
            tx_num_bytes_q <= tx_num_bytes_d;
            grant_q        <= grant_d;
        end
    end

    assign tx_bytes     = tx_bytes_q;
    assign tx_num_bytes = tx_num_bytes_q;
    assign grant_idx    = grant_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Self-checking bench for rs232_tx_arbiter: single-request vector table plus hand-written
// sequences for round-robin order, withdrawal, mid-frame reset and requester-0 priority.
module tb_rs232_tx_arbiter;

    localparam int NR = 4;
    localparam int MB = 6;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR*MB*8-1:0] req_bytes;
    logic [NR*4-1:0]   req_num_bytes;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     req_err;
    logic [MB*8-1:0]   tx_bytes;
    logic [3:0]        tx_num_bytes;
    logic              tx_valid;
    logic              busy;
    logic [2:0]        grant_idx;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    rs232_tx_arbiter #(
        .NUM_REQ      (NR),
        .MAX_BYTES    (MB),
        .BYTE_CYCLES  (12),
        .GUARD_CYCLES (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_bytes     (req_bytes),
        .req_num_bytes (req_num_bytes),
        .req_ack       (req_ack),
        .req_err       (req_err),
        .tx_bytes      (tx_bytes),
        .tx_num_bytes  (tx_num_bytes),
        .tx_valid      (tx_valid),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    typedef struct {
        int          idx;
        logic [3:0]  nb;
        logic [47:0] data;
        bit          err;
        int          blen;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [3:0] nb, input logic [47:0] d);
        req_bytes[i*48 +: 48]   = d;
        req_num_bytes[i*4 +: 4] = nb;
    endtask

    task automatic wait_launch(input int limit, output int cyc, output logic [NR-1:0] acks);
        cyc  = 0;
        acks = '0;
        do begin
            @(negedge clock);
            cyc++;
            acks |= req_ack;
        end while (!tx_valid && cyc < limit);
        check("launch seen", 64'(tx_valid), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("idle reached", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " tx_valid"}, 64'(tx_valid), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " req_ack"}, 64'(req_ack), 64'd0);
        check({tag, " req_err"}, 64'(req_err), 64'd0);
        check({tag, " tx_bytes"}, 64'(tx_bytes), 64'd0);
        check({tag, " tx_num_bytes"}, 64'(tx_num_bytes), 64'd0);
        check({tag, " grant_idx"}, 64'(grant_idx), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          blen;
        logic [NR-1:0] acks;
        logic [3:0]  last_nb;
        int          exp_order[5];
        int          exp_space[5];
        int          exp_nb[5];
        int          alt_order[4];
        int          first_b, second_b;

        vecs[0] = '{1, 4'd3,  48'hA1B2C3000000, 1'b0, 41};
        vecs[1] = '{0, 4'd6,  48'h010203040506, 1'b0, 77};
        vecs[2] = '{3, 4'd1,  48'h5A0000000000, 1'b0, 17};
        vecs[3] = '{1, 4'd15, 48'hFFEEDDCCBBAA, 1'b1, 0};
        vecs[4] = '{2, 4'd5,  48'hDEADBEEF7700, 1'b0, 65};
        vecs[5] = '{2, 4'd0,  48'h000000000000, 1'b1, 0};
        vecs[6] = '{2, 4'd7,  48'h112233445566, 1'b1, 0};

`ifdef RS232_TX_ARB_PRIO0_EN
        exp_order = '{0, 0, 0, 0, 0};
        exp_space = '{1, 18, 18, 18, 18};
        exp_nb    = '{1, 1, 1, 1, 1};
        alt_order = '{0, 0, 0, 0};
        first_b   = 0;
        second_b  = 3;
`else
        exp_order = '{0, 1, 2, 3, 0};
        exp_space = '{1, 18, 30, 42, 54};
        exp_nb    = '{1, 2, 3, 4, 1};
        alt_order = '{0, 1, 0, 1};
        first_b   = 3;
        second_b  = 0;
`endif

        // Reset state, then all four requesters held from reset.
        reset_n       = 1'b0;
        req_valid     = '0;
        req_bytes     = '0;
        req_num_bytes = '0;
        #2;
        check_all_zero("reset");
        for (int i = 0; i < NR; i++) set_slot(i, 4'(i + 1), {8'(8'h10 + i), 40'h0});
        req_valid = 4'hF;
        #1;
        check("ack masked in reset", 64'(req_ack), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_launch(100, cyc, acks);
            check($sformatf("rr grant %0d", k), 64'(grant_idx), 64'(exp_order[k]));
            check($sformatf("rr spacing %0d", k), 64'(cyc), 64'(exp_space[k]));
            check($sformatf("rr num_bytes %0d", k), 64'(tx_num_bytes), 64'(exp_nb[k]));
            check($sformatf("rr ack %0d", k), 64'(req_ack), 64'(4'b0001 << exp_order[k]));
        end
        req_valid = '0;
        wait_idle();
        last_nb = tx_num_bytes;

        // Table of single-request frames, including rejected byte counts.
        for (int v = 0; v < 7; v++) begin
            req_bytes     = '0;
            req_num_bytes = '0;
            set_slot(vecs[v].idx, vecs[v].nb, vecs[v].data);
            req_valid = 4'b0001 << vecs[v].idx;
            #1;
            if (vecs[v].err) begin
                check($sformatf("v%0d reject ack", v), 64'(req_ack), 64'(4'b0001 << vecs[v].idx));
                check($sformatf("v%0d reject err", v), 64'(req_err), 64'(4'b0001 << vecs[v].idx));
                check($sformatf("v%0d no tx_valid", v), 64'(tx_valid), 64'd0);
                @(negedge clock);
                check($sformatf("v%0d stays idle", v), 64'(busy), 64'd0);
                check($sformatf("v%0d num_bytes kept", v), 64'(tx_num_bytes), 64'(last_nb));
                req_valid = '0;
            end else begin
                check($sformatf("v%0d no early ack", v), 64'(req_ack), 64'd0);
                @(negedge clock);
                check($sformatf("v%0d tx_valid", v), 64'(tx_valid), 64'd1);
                check($sformatf("v%0d ack", v), 64'(req_ack), 64'(4'b0001 << vecs[v].idx));
                check($sformatf("v%0d err", v), 64'(req_err), 64'd0);
                check($sformatf("v%0d num_bytes", v), 64'(tx_num_bytes), 64'(vecs[v].nb));
                check($sformatf("v%0d bytes", v), 64'(tx_bytes), 64'(vecs[v].data));
                check($sformatf("v%0d grant", v), 64'(grant_idx), 64'(vecs[v].idx));
                req_valid = '0;
                last_nb   = vecs[v].nb;
                blen      = 1;
                @(negedge clock);
                check($sformatf("v%0d single pulse", v), 64'(tx_valid), 64'd0);
                while (busy && blen < 300) begin
                    blen++;
                    @(negedge clock);
                end
                check($sformatf("v%0d busy length", v), 64'(blen), 64'(vecs[v].blen));
                check($sformatf("v%0d bytes held", v), 64'(tx_bytes), 64'(vecs[v].data));
            end
        end

        // After rejecting requester 2, rr_ptr sits at 3.
        req_bytes     = '0;
        req_num_bytes = '0;
        set_slot(0, 4'd2, 48'hC0C1_0000_0000);
        set_slot(3, 4'd2, 48'hF0F1_0000_0000);
        req_valid = 4'b1001;
        wait_launch(5, cyc, acks);
        check("ptr after reject latency", 64'(cyc), 64'd1);
        check("ptr after reject grant", 64'(grant_idx), 64'(first_b));
        req_valid[first_b] = 1'b0;
        wait_launch(100, cyc, acks);
        check("second grant", 64'(grant_idx), 64'(second_b));
        check("second grant spacing", 64'(cyc), 64'd30);
        req_valid = '0;
        wait_idle();

        // Requester 3 withdraws during requester 0's WAIT and is never acked.
        set_slot(0, 4'd1, 48'hAA00_0000_0000);
        req_valid = 4'b0001;
        wait_launch(5, cyc, acks);
        check("withdraw first grant", 64'(grant_idx), 64'd0);
        set_slot(2, 4'd1, 48'h2200_0000_0000);
        set_slot(3, 4'd1, 48'h3300_0000_0000);
        req_valid = 4'b1100;
        repeat (5) @(negedge clock);
        req_valid[3] = 1'b0;
        wait_launch(100, cyc, acks);
        check("withdraw next grant", 64'(grant_idx), 64'd2);
        check("withdraw spacing", 64'(cyc), 64'd13);
        check("withdrawn never acked", 64'(acks[3]), 64'd0);
        req_valid = '0;
        wait_idle();

        // Reset during WAIT of a 6-byte frame, then rr_ptr restarts at 0.
        set_slot(1, 4'd6, 48'h123456789ABC);
        req_valid = 4'b0010;
        wait_launch(5, cyc, acks);
        check("pre-reset grant", 64'(grant_idx), 64'd1);
        req_valid = '0;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid-frame reset");
        @(negedge clock);
        reset_n = 1'b1;
        set_slot(1, 4'd2, 48'h4142_0000_0000);
        set_slot(3, 4'd2, 48'h4344_0000_0000);
        req_valid = 4'b1010;
        wait_launch(5, cyc, acks);
        check("post-reset latency", 64'(cyc), 64'd1);
        check("post-reset grant", 64'(grant_idx), 64'd1);
        check("post-reset bytes", 64'(tx_bytes), 64'h4142_0000_0000);
        req_valid = '0;
        wait_idle();

        // Requesters 0 and 1 held: alternate, or requester 0 only with priority.
        set_slot(0, 4'd1, 48'h0A00_0000_0000);
        set_slot(1, 4'd1, 48'h0B00_0000_0000);
        req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            wait_launch(100, cyc, acks);
            check($sformatf("pair grant %0d", k), 64'(grant_idx), 64'(alt_order[k]));
            check($sformatf("pair spacing %0d", k), 64'(cyc), (k == 0) ? 64'd1 : 64'd18);
        end
        req_valid = '0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs232_tx_arbiter.md
Name: rs232_tx_arbiter

Overview:
- Shares the single RS232 encoder transmit port between NUM_REQ on-board requesters, e.g. the command-response path, housekeeping telemetry and error reporting.
- Selects one pending frame by round-robin and launches it with a one-cycle tx_valid pulse.
- The encoder has no busy output, so the arbiter holds off for a computed per-frame duration before granting again.
- Sits between the requesters and the encoder and runs on the encoder's transmit (bit-rate) clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BYTES, 6, bytes per frame slot; must match the encoder's MAX_BYTES.
- BYTE_CYCLES, 12, clock cycles the encoder spends per byte, including inter-byte overhead.
- GUARD_CYCLES, 4, extra idle cycles after each frame before the next launch.

Ports:
- clock  in  1  transmit bit-rate clock, shared with the encoder.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester frame pending; level, held until ack.
- req_bytes  in  NUM_REQ*MAX_BYTES*8  per-requester payload; slot i = bits [(i+1)*MAX_BYTES*8-1 : i*MAX_BYTES*8]; first byte in the MS byte of the slot.
- req_num_bytes  in  NUM_REQ*4  per-requester byte count; slot i = bits [4i+3:4i].
- req_ack  out  NUM_REQ  one-cycle pulse: frame taken, or rejected.
- req_err  out  NUM_REQ  one-cycle pulse with req_ack when the frame was rejected.
- tx_bytes  out  MAX_BYTES*8  to encoder.
- tx_num_bytes  out  4  to encoder.
- tx_valid  out  1  to encoder; one-cycle launch pulse.
- busy  out  1  high in LAUNCH and WAIT.
- grant_idx  out  3  index of the last granted requester.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; rr_ptr=0; hold counter=0; all outputs 0, including tx_bytes, tx_num_bytes, grant_idx and busy. A reset mid-frame aborts immediately. The encoder shares the reset, so no partial-frame recovery is needed.
- Requester handshake:
  - Requester asserts req_valid[i] with stable req_bytes/req_num_bytes and holds until req_ack[i].
  - Dropping req_valid before ack withdraws the request; this is legal and the request is never granted.
  - After ack, the requester deasserts or presents a new frame. The arbiter samples it again no earlier than the next IDLE cycle.
- IDLE:
  - If no req_valid: stay.
  - Else winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If winner's num_bytes==0 or >MAX_BYTES: pulse req_ack and req_err for the winner, set rr_ptr=winner+1 mod NUM_REQ, stay IDLE, no tx_valid. This guards the encoder's byte counter against runaway.
  - Otherwise: register winner's bytes and count into tx_bytes/tx_num_bytes, set grant_idx=winner, set rr_ptr=winner+1 mod NUM_REQ, go to LAUNCH.
- LAUNCH (1 cycle):
  - tx_valid=1 and req_ack[grant_idx]=1 in the same cycle.
  - Load hold counter = num_bytes*BYTE_CYCLES + GUARD_CYCLES.
  - Go to WAIT.
- WAIT:
  - Counter decrements each cycle; at 0, go to IDLE.
  - New requests are ignored.
  - tx_bytes/tx_num_bytes hold their last value.
- Timing: minimum request-to-tx_valid latency is 2 cycles (IDLE register, then LAUNCH pulse).
  - Back-to-back grant spacing = 1 + num_bytes*BYTE_CYCLES + GUARD_CYCLES + 1 cycles.
- Hold counter is 10 bits, which is sufficient for 15*63+GUARD_CYCLES; BYTE_CYCLES ≤ 63 and GUARD_CYCLES ≤ 63.
- Multiplication uses constant BYTE_CYCLES and is truncation-free at 10 bits.
- Simultaneous requests resolve by round-robin only; a requester asserting in the same cycle as another's ack waits its turn.

Optional Feature:
- Macro RS232_TX_ARB_PRIO0_EN.
- Defined: requester 0 wins in IDLE whenever req_valid[0]=1, regardless of rr_ptr. rr_ptr is still updated to 1 after a requester-0 grant. Used for the fault/error reporter.
- Undefined: pure round-robin across all requesters.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/LAUNCH/WAIT);
  - defaults for BYTE_CYCLES and GUARD_CYCLES;
  - the 4-bit byte-count width constant, shared with the encoder.
- One sub-module, rs232_rr_pick: combinational rotate/priority-find. Inputs are the req vector and rr_ptr; outputs are winner index and found flag.

Test Plan:
- Single request: req 1, 3 bytes A1B2C3 -> tx_valid pulse 2 cycles after req_valid, tx_num_bytes=3, tx_bytes MS bytes A1,B2,C3, req_ack[1] coincident, busy high for 1+40 cycles.
- All 4 requesters held continuously from reset -> grant order 0,1,2,3,0. Each launch is spaced 1+n*12+4+1 cycles after the previous.
- Requester 2 with num_bytes=0, then 7 (MAX_BYTES=6) -> req_ack[2] and req_err[2] pulse, no tx_valid, rr_ptr advances to 3.
- Requester 3 withdraws req_valid during WAIT of requester 0's frame -> requester 3 never acked, next grant goes to the next pending requester.
- reset_n low during WAIT of a 6-byte frame -> all outputs 0 the same cycle. After release, a new request launches normally with rr_ptr=0.
- With RS232_TX_ARB_PRIO0_EN, requesters 0 and 1 held continuously -> only requester 0 granted. Without the macro -> 0,1 alternate.
